// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: synchronizes and debounces A/B, then turns
// full detent cycles into registered step/up pulses and flags illegal jumps.
module quad_decoder #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enc_a,
  input  logic enc_b,
  input  logic en,
  input  logic err_clr,
  output logic step,
  output logic up,
  output logic err,
  output logic err_sticky
);

  localparam logic [7:0] FLT_LAST  = 8'(FILTER_LEN - 1);
  localparam logic [8:0] PRIME_LEN = 9'(FILTER_LEN + 3);

  // Bit 1 is channel A, bit 0 is channel B, so vectors read as phase {A,B}.
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      filt_q, filt_d;
  logic [1:0][7:0] fcnt_q, fcnt_d;
  logic [1:0]      prev_q;
  logic [8:0]      prime_q, prime_d;
  logic signed [3:0] q_q, q_d, q_new;
  logic step_q, step_d;
  logic up_q, up_d;
  logic err_q, err_d;
  logic sticky_q, sticky_d;
  logic primed, active, fwd, bwd, illegal;

  function automatic logic [1:0] cw_next(input logic [1:0] p);
    case (p)
      2'b00:   cw_next = 2'b10;
      2'b10:   cw_next = 2'b11;
      2'b11:   cw_next = 2'b01;
      default: cw_next = 2'b00;
    endcase
  endfunction

  // A mismatch streak of FILTER_LEN cycles commits the synchronized value.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FLT_LAST) filt_d[i] = sync2_q[i];
        else                       fcnt_d[i] = fcnt_q[i] + 8'd1;
      end
    end
  end

  assign primed  = (prime_q == PRIME_LEN);
  assign prime_d = primed ? prime_q : prime_q + 9'd1;
  assign active  = en && primed;
  assign fwd     = (filt_q == cw_next(prev_q));
  assign bwd     = (prev_q == cw_next(filt_q));
  assign illegal = ((filt_q ^ prev_q) == 2'b11);
  assign q_new   = fwd ? q_q + 4'sd1 : q_q - 4'sd1;

  always_comb begin
    q_d    = q_q;
    step_d = 1'b0;
    err_d  = 1'b0;
    up_d   = up_q;
    if (!active) begin
      q_d = '0;
    end else if (illegal) begin
      err_d = 1'b1;
      q_d   = '0;
    end else if (fwd || bwd) begin
      if (filt_q == 2'b00) begin
        // Only a full four-quarter trip through the cycle counts as a detent.
        q_d = '0;
        if (q_new == 4'sd4) begin
          step_d = 1'b1;
          up_d   = 1'b1;
        end else if (q_new == -4'sd4) begin
          step_d = 1'b1;
          up_d   = 1'b0;
        end
      end else begin
        q_d = q_new;
      end
    end
  end

  assign sticky_d = err_clr ? 1'b0 : (err_d ? 1'b1 : sticky_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      filt_q   <= '0;
      fcnt_q   <= '0;
      prev_q   <= '0;
      prime_q  <= '0;
      q_q      <= '0;
      step_q   <= 1'b0;
      up_q     <= 1'b1;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      sync1_q  <= {enc_a, enc_b};
      sync2_q  <= sync1_q;
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      prev_q   <= filt_q;
      prime_q  <= prime_d;
      q_q      <= q_d;
      step_q   <= step_d;
      up_q     <= up_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign step       = step_q;
  assign up         = up_q;
  assign err        = err_q;
  assign err_sticky = sticky_q;

endmodule
